// File: rtl/alu_branch_unit_if.sv
// rtl/alu_branch_unit_if.sv - execute-stage ALU/branch bundle between control FSM and datapath
interface alu_branch_unit_if #(parameter int WIDTH = 32);
    logic             en;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] read_data1;
    logic [4:0]       shamt;
    logic             select_shamt;
    logic [WIDTH-1:0] alu_srcB;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             overflow;
    logic             alu_zero;
    logic             alu_done;
    logic             branch_en;
    logic             branch;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_out;
    logic             branch_done;

    modport master (
        output en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
        output branch_en, branch, imm, pc,
        input  alu_result, hi, lo, overflow, alu_zero, alu_done,
        input  pc_out, branch_done
    );

    modport slave (
        input  en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
        input  branch_en, branch, imm, pc,
        output alu_result, hi, lo, overflow, alu_zero, alu_done,
        output pc_out, branch_done
    );
endinterface

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - registered ALU with HI/LO multiply plus branch-target unit
module alu_branch_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    alu_branch_unit_if.slave bus
);
    localparam int W = WIDTH;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [4:0]     sh;
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic           mul_signed;
    logic           is_mul;
    logic [2*W-1:0] mul_a;
    logic [2*W-1:0] mul_b;
    logic [2*W-1:0] product;
    logic [W-1:0]   res_next;
    logic           ovf_next;

    logic [W-1:0]   alu_result_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           overflow_q;
    logic           alu_zero_q;
    logic           alu_done_q;
    logic [W-1:0]   pc_out_q;
    logic           branch_done_q;

    assign op_a = bus.select_shamt ? {{(W-5){1'b0}}, bus.shamt} : bus.read_data1;
    assign op_b = bus.alu_srcB;
    assign sh   = op_a[4:0];
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // One double-width multiplier serves both MULT and MULTU; only the operand extension differs.
    assign mul_signed = (bus.alu_control == 4'b1011);
    assign is_mul     = (bus.alu_control == 4'b1011) || (bus.alu_control == 4'b1100);
    assign mul_a      = {{W{mul_signed & op_a[W-1]}}, op_a};
    assign mul_b      = {{W{mul_signed & op_b[W-1]}}, op_b};
    assign product    = mul_a * mul_b;

    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        case (bus.alu_control)
            4'b0000: res_next = op_a & op_b;
            4'b0001: res_next = op_a | op_b;
            4'b0010: begin
                res_next = sum;
                ovf_next = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
            end
            4'b0011: res_next = sum;
            4'b0100: res_next = op_a ^ op_b;
            4'b0101: res_next = ~(op_a | op_b);
            4'b0110: begin
                res_next = diff;
                ovf_next = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
            end
            4'b0111: res_next = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1000: res_next = op_b << sh;
            4'b1001: res_next = op_b >> sh;
            4'b1010: res_next = $signed(op_b) >>> sh;
            4'b1011: res_next = product[W-1:0];
            4'b1100: res_next = product[W-1:0];
            4'b1101: res_next = diff;
            4'b1110: res_next = {{(W-1){1'b0}}, (op_a < op_b)};
            default: res_next = op_b << 16;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q  <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            overflow_q    <= 1'b0;
            alu_zero_q    <= 1'b0;
            alu_done_q    <= 1'b0;
            pc_out_q      <= '0;
            branch_done_q <= 1'b0;
        end else begin
            if (!bus.en) begin
                alu_done_q <= 1'b0;
            end else if (!alu_done_q) begin
                alu_result_q <= res_next;
                overflow_q   <= ovf_next;
                alu_zero_q   <= (res_next == '0);
                alu_done_q   <= 1'b1;
                if (is_mul) begin
                    hi_q <= product[2*W-1:W];
                    lo_q <= product[W-1:0];
                end
            end

            // alu_zero_q here is the pre-edge value, even when the ALU updates on the same edge.
            if (!bus.branch_en) begin
                branch_done_q <= 1'b0;
            end else if (!branch_done_q) begin
                pc_out_q      <= (bus.branch && alu_zero_q) ? bus.pc + bus.imm : bus.pc;
                branch_done_q <= 1'b1;
            end
        end
    end

    assign bus.alu_result  = alu_result_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.overflow    = overflow_q;
    assign bus.alu_zero    = alu_zero_q;
    assign bus.alu_done    = alu_done_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.branch_done = branch_done_q;
endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - vector table and scoreboard bench for alu_branch_unit
module tb_alu_branch_unit;
    logic clk;
    logic rst;

    alu_branch_unit_if #(.WIDTH(32)) bus ();

    alu_branch_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic        sel;
        logic [4:0]  shamt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        mul;
        logic [31:0] hi;
        logic [31:0] lo;
    } alu_vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
    } alu_exp_t;

    alu_vec_t    vecs[$];
    alu_exp_t    alu_q[$];
    logic [31:0] br_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          checks;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic alu_vec_t mk(input logic [3:0] c, input logic s, input logic [4:0] sa,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] r, input logic o, input logic z,
                                    input logic m, input logic [31:0] h, input logic [31:0] l);
        alu_vec_t v;
        v.ctrl = c; v.sel = s; v.shamt = sa; v.a = a; v.b = b;
        v.res = r; v.ovf = o; v.zero = z; v.mul = m; v.hi = h; v.lo = l;
        return v;
    endfunction

    task automatic run_alu(input alu_vec_t v, input int hold);
        alu_exp_t e;
        int cyc;
        @(negedge clk);
        bus.alu_control  = v.ctrl;
        bus.select_shamt = v.sel;
        bus.shamt        = v.shamt;
        bus.read_data1   = v.a;
        bus.alu_srcB     = v.b;
        bus.en           = 1'b1;
        if (v.mul) begin
            model_hi = v.hi;
            model_lo = v.lo;
        end
        e.res = v.res; e.ovf = v.ovf; e.zero = v.zero; e.hi = model_hi; e.lo = model_lo;
        alu_q.push_back(e);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.alu_done && cyc < 8);
        check("alu_latency", 32'(cyc), 32'd1);
        if (alu_q.size() > 0) begin
            e = alu_q.pop_front();
            check("alu_result", bus.alu_result, e.res);
            check("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
            check("alu_zero", {31'b0, bus.alu_zero}, {31'b0, e.zero});
            check("hi", bus.hi, e.hi);
            check("lo", bus.lo, e.lo);
        end
        // Operands change under a held enable; the registered result must not follow them.
        for (int i = 0; i < hold; i++) begin
            bus.read_data1 = ~v.a;
            bus.alu_srcB   = ~v.b;
            bus.shamt      = ~v.shamt;
            @(negedge clk);
            check("hold_done", {31'b0, bus.alu_done}, 32'd1);
            check("hold_result", bus.alu_result, e.res);
        end
        bus.en = 1'b0;
        @(negedge clk);
        check("drop_done", {31'b0, bus.alu_done}, 32'd0);
        check("drop_result", bus.alu_result, e.res);
    endtask

    task automatic run_branch(input logic br, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] exp_pc);
        logic [31:0] e;
        int cyc;
        @(negedge clk);
        bus.branch    = br;
        bus.pc        = pc;
        bus.imm       = imm;
        bus.branch_en = 1'b1;
        br_q.push_back(exp_pc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.branch_done && cyc < 8);
        check("branch_latency", 32'(cyc), 32'd1);
        e = br_q.pop_front();
        check("pc_out", bus.pc_out, e);
        bus.pc = pc + 32'h100;
        @(negedge clk);
        check("branch_hold", bus.pc_out, e);
        bus.branch_en = 1'b0;
        @(negedge clk);
        check("branch_drop_done", {31'b0, bus.branch_done}, 32'd0);
        check("branch_drop_pc", bus.pc_out, e);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        bus.en = 1'b1; bus.alu_control = 4'b0010; bus.read_data1 = 32'd5; bus.shamt = 5'd0;
        bus.select_shamt = 1'b0; bus.alu_srcB = 32'd7;
        bus.branch_en = 1'b1; bus.branch = 1'b1; bus.imm = 32'd4; bus.pc = 32'h40;
        rst = 1'b1;

        vecs.push_back(mk(4'b0010, 0, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1000, 1, 5'd4,  32'hFFFFFFFF, 32'h0000000F, 32'h000000F0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1010, 1, 5'd31, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1011, 0, 5'd0,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFF1));
        vecs.push_back(mk(4'b0010, 0, 5'd0,  32'h00000002, 32'h00000002, 32'h00000004, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1100, 0, 5'd0,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0, 0, 1, 32'h00000001, 32'hFFFFFFFE));
        vecs.push_back(mk(4'b0000, 0, 5'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 0, 5'd0,  32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0100, 0, 5'd0,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0101, 0, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0110, 0, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0111, 0, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1110, 0, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(4'b1001, 0, 5'd0,  32'h00000024, 32'h80000000, 32'h08000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0011, 0, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1101, 0, 5'd0,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1111, 0, 5'd0,  32'hDEADBEEF, 32'h00001234, 32'h12340000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0010, 0, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 0, 0, 0));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_alu_done", {31'b0, bus.alu_done}, 32'd0);
            check("rst_branch_done", {31'b0, bus.branch_done}, 32'd0);
            check("rst_result", bus.alu_result, 32'd0);
            check("rst_hi_lo", bus.hi | bus.lo, 32'd0);
            check("rst_flags", {30'b0, bus.overflow, bus.alu_zero}, 32'd0);
            check("rst_pc_out", bus.pc_out, 32'd0);
        end
        bus.en = 1'b0;
        bus.branch_en = 1'b0;
        rst = 1'b0;

        run_alu(vecs[0], 3);
        for (int i = 1; i < vecs.size(); i++) run_alu(vecs[i], 1);

        // Taken branch backwards, then not-taken, then branch=0 with zero set, then wrap.
        run_alu(mk(4'b0110, 0, 5'd0, 32'd7, 32'd7, 32'd0, 0, 1, 0, 0, 0), 0);
        run_branch(1'b1, 32'h00000010, 32'hFFFFFFFC, 32'h0000000C);
        run_alu(mk(4'b0010, 0, 5'd0, 32'd2, 32'd2, 32'd4, 0, 0, 0, 0, 0), 0);
        run_branch(1'b1, 32'h00000010, 32'hFFFFFFFC, 32'h00000010);
        run_alu(mk(4'b0110, 0, 5'd0, 32'd9, 32'd9, 32'd0, 0, 1, 0, 0, 0), 0);
        run_branch(1'b0, 32'h00000020, 32'h00000008, 32'h00000020);
        run_branch(1'b1, 32'hFFFFFFFC, 32'h00000008, 32'h00000004);

        // Same-edge start: branch must see alu_zero=1 from before the ADD lands.
        @(negedge clk);
        bus.alu_control = 4'b0010; bus.select_shamt = 1'b0;
        bus.read_data1 = 32'd2; bus.alu_srcB = 32'd2; bus.en = 1'b1;
        bus.branch = 1'b1; bus.pc = 32'h00000100; bus.imm = 32'h00000010; bus.branch_en = 1'b1;
        @(negedge clk);
        check("same_edge_pc_out", bus.pc_out, 32'h00000110);
        check("same_edge_result", bus.alu_result, 32'd4);
        check("same_edge_zero", {31'b0, bus.alu_zero}, 32'd0);
        check("same_edge_dones", {30'b0, bus.alu_done, bus.branch_done}, 32'd3);
        bus.en = 1'b0;
        bus.branch_en = 1'b0;
        @(negedge clk);

        // Reset during an enabled operation clears everything and suppresses the result.
        bus.alu_control = 4'b1011; bus.read_data1 = 32'hFFFFFFFD; bus.alu_srcB = 32'd5;
        bus.en = 1'b1; bus.branch_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", {30'b0, bus.alu_done, bus.branch_done}, 32'd0);
        check("abort_result", bus.alu_result | bus.hi | bus.lo | bus.pc_out, 32'd0);
        rst = 1'b0;
        bus.en = 1'b0;
        bus.branch_en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_branch_unit.md
Name: alu_branch_unit

Overview:
Execute-stage datapath block of the multi-cycle MIPS core. It contains three parts:
- an operand-A select mux (register value or zero-extended shamt);
- a registered 32-bit ALU with HI/LO multiply results, overflow and zero flags;
- a registered branch-target unit that produces the next PC.

The control FSM drives it with level enables and waits on the done flags.

Parameters:
- WIDTH, 32, datapath width (all operands, results, PC).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en  in  1  ALU enable (level, held by FSM until alu_done seen)
- alu_control  in  4  ALU operation code
- read_data1  in  32  rs register value
- shamt  in  5  instruction shift amount
- select_shamt  in  1  1: operand A = {27'b0,shamt}; 0: operand A = read_data1
- alu_srcB  in  32  operand B (rt value or extended immediate, muxed upstream)
- alu_result  out  32  registered ALU result
- hi  out  32  registered upper multiply product
- lo  out  32  registered lower multiply product
- overflow  out  1  registered signed-overflow flag
- alu_zero  out  1  registered (alu_result == 0)
- alu_done  out  1  ALU result valid
- branch_en  in  1  branch-unit enable (level)
- branch  in  1  instruction is a conditional branch
- imm  in  32  sign-extended word offset
- pc  in  32  current PC (already incremented, word-addressed)
- pc_out  out  32  registered next PC
- branch_done  out  1  pc_out valid

Behaviour:
- Reset (rst=1 at posedge): all outputs go to 0. Reset overrides en and branch_en and aborts any operation.
- Operand A mux is combinational: A = select_shamt ? {27'b0,shamt} : read_data1. B = alu_srcB.

ALU handshake:
- At a posedge with en=1 and alu_done=0: compute the operation, register alu_result, alu_zero, overflow (and hi/lo where applicable), and set alu_done=1. Latency is one cycle.
- While en stays 1 with alu_done=1: outputs hold and no recompute happens.
- At a posedge with en=0: alu_done<=0; alu_result, hi, lo, overflow and alu_zero hold their values.
- Deasserting en for one cycle then reasserting it starts a new operation.

ALU opcodes (arithmetic is modulo 2^32):
- 0000 AND
- 0001 OR
- 0010 ADD, signed overflow flagged
- 0011 ADDU, no overflow
- 0100 XOR
- 0101 NOR
- 0110 SUB (A−B), signed overflow flagged
- 0111 SLT signed, result 1 or 0
- 1000 SLL: B << A[4:0]
- 1001 SRL: B >> A[4:0], logical
- 1010 SRA: B >>> A[4:0], arithmetic
- 1011 MULT: signed 64-bit {hi,lo}=A*B; alu_result=lo
- 1100 MULTU: unsigned, as MULT
- 1101 SUBU, no overflow
- 1110 SLTU
- 1111 LUI: B << 16

ALU rules:
- Shifts use only A[4:0]; upper A bits are ignored.
- overflow is 0 for every op except ADD and SUB. Signed overflow means the operands have equal sign (ADD) or opposite sign (SUB) and the result sign differs from A. The result is still written on overflow; there is no trap.
- hi and lo change only on MULT/MULTU; every other op leaves them unchanged.
- alu_zero equals (new alu_result == 0) and is registered in the same edge as alu_result.

Branch handshake:
- At a posedge with branch_en=1 and branch_done=0: pc_out <= (branch & alu_zero) ? pc + imm : pc, and branch_done<=1.
- While branch_en=1 with branch_done=1: hold.
- At a posedge with branch_en=0: branch_done<=0 and pc_out holds.
- The branch unit uses the registered alu_zero value as it stands before that edge.
- If en and branch_en are both high on the same edge, the branch uses the pre-update alu_zero.
- pc+imm wraps modulo 2^32; a negative imm moves the PC backwards.
- The two engines are independent; either can run while the other is idle.

Test Plan:
- Reset: drive rst=1 with en=1 → all outputs 0 after the edge; alu_done stays 0 while rst is held.
- ADD overflow: A=0x7FFFFFFF, B=1, ctrl=0010, en=1 → one cycle later alu_result=0x80000000, overflow=1, alu_done=1; hold en 3 more cycles → outputs stable; drop en → alu_done=0 next edge, result held.
- SLL via shamt: select_shamt=1, shamt=4, read_data1=0xFFFFFFFF, B=0x0000000F, ctrl=1000 → result 0x000000F0. SRA with B=0x80000000, shamt=31 → 0xFFFFFFFF.
- MULT: A=−3 (0xFFFFFFFD), B=5, ctrl=1011 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. A following ADD (2+2) → hi/lo unchanged, result=4, alu_zero=0.
- BEQ taken: SUB 7−7 → alu_zero=1; then branch_en=1, branch=1, pc=0x10, imm=0xFFFFFFFC → pc_out=0x0C, branch_done=1. Not taken (alu_zero=0) → pc_out=0x10.
- Branch with branch=0 and alu_zero=1, pc=0x20, imm=8 → pc_out=0x20. Dropping branch_en → branch_done=0, pc_out holds 0x20.
